// File: rtl/microcode_sequencer_if.sv
// Instruction handshake, datapath control bus and control-store write port of microcode_sequencer.
// master = instruction/store source side, slave = sequencer side.
interface microcode_sequencer_if #(
  parameter int unsigned CTRL_W = 21,
  parameter int unsigned ADDR_W = 9
);
  localparam int unsigned UW = CTRL_W + 2 + ADDR_W;

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic              ex_done;
  logic              cond_in;
  logic              stall;
  logic              ctrl_valid;
  logic [CTRL_W-1:0] ctrl_signals;
  logic              ucode_we;
  logic [ADDR_W-1:0] ucode_waddr;
  logic [UW-1:0]     ucode_wdata;
  logic              ucode_wpar;
  logic              ucode_err;

  modport master (
    output instr_valid, instruction, ex_done, cond_in, stall,
           ucode_we, ucode_waddr, ucode_wdata, ucode_wpar,
    input  instr_ready, ctrl_valid, ctrl_signals, ucode_err
  );

  modport slave (
    input  instr_valid, instruction, ex_done, cond_in, stall,
           ucode_we, ucode_waddr, ucode_wdata, ucode_wpar,
    output instr_ready, ctrl_valid, ctrl_signals, ucode_err
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Micro-programmed control unit: dispatches RISC-V instructions into a writable control store
// and sequences microwords (END/STAY/JUMP/COND). Optional store parity: define UCODE_PARITY_EN.
module microcode_sequencer #(
  parameter int unsigned CTRL_W = 21,
  parameter int unsigned ADDR_W = 9
) (
  input logic                clk,
  input logic                rstn,
  microcode_sequencer_if.slave bus
);
  localparam int unsigned UW    = CTRL_W + 2 + ADDR_W;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef UCODE_PARITY_EN
  localparam int unsigned SW = UW + 1;
`else
  localparam int unsigned SW = UW;
`endif

  typedef enum logic [1:0] {
    SEQ_END  = 2'b00,
    SEQ_STAY = 2'b01,
    SEQ_JUMP = 2'b10,
    SEQ_COND = 2'b11
  } seq_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    seq_e              seq;
    logic [ADDR_W-1:0] nxt_addr;
  } uword_t;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state;
  logic [ADDR_W-1:0] upc;
  logic [SW-1:0]     store [DEPTH];
  uword_t            uword;
  logic [ADDR_W-1:0] dispatch;
  logic              fetch;
  logic              par_bad;
  logic              issue;
  logic              seq_end;
  logic              seq_jump;
  logic              unused_bits;

  // Dispatch address {opcode[6:2], funct3 or 0, instr[30] or 0}
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       use_f3;
    logic       b30;
    opcode   = bus.instruction[6:0];
    funct3   = bus.instruction[14:12];
    use_f3   = opcode inside {7'b0110011, 7'b0010011, 7'b0000011,
                              7'b1100111, 7'b0100011, 7'b1100011};
    b30      = bus.instruction[30] &&
               ((opcode == 7'b0110011) || ((opcode == 7'b0010011) && (funct3 == 3'b101)));
    dispatch = ADDR_W'({opcode[6:2], (use_f3 ? funct3 : 3'b000), b30});
  end

  assign unused_bits = ^{bus.instruction[31], bus.instruction[29:15],
                         bus.instruction[11:7], bus.ucode_wpar};

  // Control store: no reset, write lands at the edge so a same-cycle fetch sees the old word
  always_ff @(posedge clk) begin
    if (bus.ucode_we) begin
`ifdef UCODE_PARITY_EN
      store[bus.ucode_waddr] <= {bus.ucode_wpar, bus.ucode_wdata};
`else
      store[bus.ucode_waddr] <= bus.ucode_wdata;
`endif
    end
  end

  assign uword = uword_t'(store[upc][UW-1:0]);

`ifdef UCODE_PARITY_EN
  assign par_bad = ^store[upc];
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    seq_end  = 1'b0;
    seq_jump = 1'b0;
    fetch    = (state == RUN) && !bus.stall;
    issue    = fetch && !par_bad;
    case (uword.seq)
      SEQ_END:  seq_end  = 1'b1;
      SEQ_STAY: seq_end  = bus.ex_done;
      SEQ_JUMP: seq_jump = 1'b1;
      SEQ_COND: begin
        seq_jump = bus.cond_in;
        seq_end  = !bus.cond_in;
      end
    endcase
  end

  assign bus.ctrl_valid   = issue;
  assign bus.ctrl_signals = issue ? uword.ctrl : '0;
  assign bus.instr_ready  = (state == IDLE) || (issue && seq_end);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      upc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            upc   <= dispatch;
            state <= RUN;
          end
        end
        RUN: begin
          if (fetch) begin
            if (par_bad) begin
              state <= IDLE;
            end else if (seq_jump) begin
              upc <= uword.nxt_addr;
            end else if (seq_end) begin
              if (bus.instr_valid) upc <= dispatch;
              else                 state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UCODE_PARITY_EN
  logic err;

  // Error pulse lands in the cycle after the faulty fetch
  always_ff @(posedge clk) begin
    if (!rstn) err <= 1'b0;
    else       err <= fetch && par_bad;
  end

  assign bus.ucode_err = err;
`else
  assign bus.ucode_err = 1'b0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_microcode_sequencer;
  localparam int unsigned CTRL_W = 21;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned UW     = CTRL_W + 2 + ADDR_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_STAY = 32'h4020F0B3;  // OP, funct3=111, bit30=1 -> 0x0CF

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  microcode_sequencer_if #(.CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) bus ();

  microcode_sequencer #(.CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a copy of the store plus "busy at address pc"
  logic [UW-1:0]     m_store [DEPTH];
  logic              m_busy = 1'b0;
  logic              m_err  = 1'b0;
  logic              m_ok   = 1'b0;
  logic [ADDR_W-1:0] m_pc   = '0;

  function automatic int disp(input logic [31:0] ins);
    int op, f3, b30;
    op  = int'(ins[6:0]);
    f3  = 0;
    b30 = 0;
    if (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h67 || op == 'h23 || op == 'h63)
      f3 = int'(ins[14:12]);
    if (op == 'h33 || (op == 'h13 && ins[14:12] == 3'd5))
      b30 = int'(ins[30]);
    return (op / 4) * 16 + f3 * 2 + b30;
  endfunction

  logic [UW-1:0]     e_w;
  logic [CTRL_W-1:0] e_ctrl;
  logic [1:0]        e_seq;
  logic [ADDR_W-1:0] e_next;
  logic              e_perr, e_fetch, e_done, e_jump, e_cv, e_rdy;
  logic [CTRL_W-1:0] e_cs;

  assign e_w     = m_store[m_pc];
  assign e_ctrl  = e_w[UW-1 -: CTRL_W];
  assign e_seq   = e_w[ADDR_W+1:ADDR_W];
  assign e_next  = e_w[ADDR_W-1:0];
  assign e_fetch = m_busy && !bus.stall;
  assign e_done  = (e_seq == 2'd0) || (e_seq == 2'd1 && bus.ex_done) || (e_seq == 2'd3 && !bus.cond_in);
  assign e_jump  = (e_seq == 2'd2) || (e_seq == 2'd3 && bus.cond_in);
  assign e_cv    = e_fetch && !e_perr;
  assign e_cs    = e_cv ? e_ctrl : '0;
  assign e_rdy   = !m_busy || (e_cv && e_done);

`ifdef UCODE_PARITY_EN
  logic m_par [DEPTH];
  assign e_perr = (^e_w) != m_par[m_pc];
  always @(posedge clk) if (bus.ucode_we) m_par[bus.ucode_waddr] <= bus.ucode_wpar;
`else
  assign e_perr = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rstn) begin
      m_busy <= 1'b0;
      m_pc   <= '0;
      m_err  <= 1'b0;
      m_ok   <= 1'b1;
    end else begin
      m_err <= e_fetch && e_perr;
      if (!m_busy) begin
        if (bus.instr_valid) begin
          m_busy <= 1'b1;
          m_pc   <= ADDR_W'(disp(bus.instruction));
        end
      end else if (e_fetch) begin
        if (e_perr)      m_busy <= 1'b0;
        else if (e_jump) m_pc <= e_next;
        else if (e_done) begin
          if (bus.instr_valid) m_pc <= ADDR_W'(disp(bus.instruction));
          else                 m_busy <= 1'b0;
        end
      end
    end
    if (bus.ucode_we) m_store[bus.ucode_waddr] <= bus.ucode_wdata;
  end

  // Hand-computed expectations posted by the directed scenarios
  logic              pin_on = 1'b0;
  string             pin_name = "";
  logic              pin_cv, pin_rdy, pin_err;
  logic [CTRL_W-1:0] pin_cs;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Single compare process: model every cycle, literal pins when posted
  always @(negedge clk) begin
    if (m_ok) begin
      chk("ctrl_valid",   32'(bus.ctrl_valid),   32'(e_cv));
      chk("ctrl_signals", 32'(bus.ctrl_signals), 32'(e_cs));
      chk("instr_ready",  32'(bus.instr_ready),  32'(e_rdy));
      chk("ucode_err",    32'(bus.ucode_err),    32'(m_err));
    end
    if (pin_on) begin
      chk({pin_name, ".cv"},   32'(bus.ctrl_valid),   32'(pin_cv));
      chk({pin_name, ".ctrl"}, 32'(bus.ctrl_signals), 32'(pin_cs));
      chk({pin_name, ".rdy"},  32'(bus.instr_ready),  32'(pin_rdy));
      chk({pin_name, ".err"},  32'(bus.ucode_err),    32'(pin_err));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic cv, input logic [CTRL_W-1:0] cs,
                     input logic rdy, input logic err = 1'b0);
    pin_name = nm;
    pin_cv   = cv;
    pin_cs   = cs;
    pin_rdy  = rdy;
    pin_err  = err;
    pin_on   = 1'b1;
    @(negedge clk);
    #1;
    pin_on   = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [UW-1:0] w, input logic bad_par = 1'b0);
    bus.ucode_we    = 1'b1;
    bus.ucode_waddr = a;
    bus.ucode_wdata = w;
    bus.ucode_wpar  = (^w) ^ bad_par;
    nxt();
    bus.ucode_we    = 1'b0;
  endtask

  function automatic logic [UW-1:0] uw(input logic [CTRL_W-1:0] c, input logic [1:0] s,
                                       input logic [ADDR_W-1:0] n);
    return {c, s, n};
  endfunction

  function automatic logic [UW-1:0] rand_word();
    int r;
    logic [1:0] s;
    r = int'($urandom_range(0, 99));
    s = (r < 50) ? 2'd0 : (r < 70) ? 2'd1 : (r < 85) ? 2'd2 : 2'd3;
    return uw(CTRL_W'($urandom), s, ADDR_W'($urandom));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [8];
    logic [31:0] x;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F};
    x = $urandom;
    x[6:0] = ops[$urandom_range(0, 7)];
    return x;
  endfunction

  task automatic send(input logic [31:0] ins);
    bus.instr_valid = 1'b1;
    bus.instruction = ins;
    nxt();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.ex_done     = 1'b0;
    bus.cond_in     = 1'b0;
    bus.stall       = 1'b0;
    bus.ucode_we    = 1'b0;
    bus.ucode_waddr = '0;
    bus.ucode_wdata = '0;
    bus.ucode_wpar  = 1'b0;
    rstn = 1'b0;
    repeat (3) nxt();
    pin("reset", 1'b0, '0, 1'b1);
    rstn = 1'b1;
    nxt();

    for (int a = 0; a < int'(DEPTH); a++) wr(ADDR_W'(a), rand_word());

    // Single-word add: 1-cycle latency, ready in the same cycle
    wr(9'h0C0, uw(21'h00001, 2'b00, 9'h000));
    send(I_ADD);
    pin("add", 1'b1, 21'h00001, 1'b1);
    nxt();

    // STAY word held until ex_done on the 4th cycle, then back-to-back add
    wr(9'h0CF, uw(21'h0ABCD, 2'b01, 9'h000));
    send(I_STAY);
    for (int i = 0; i < 3; i++) begin
      pin("stay", 1'b1, 21'h0ABCD, 1'b0);
      nxt();
    end
    bus.ex_done = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instruction = I_ADD;
    pin("stay_end", 1'b1, 21'h0ABCD, 1'b1);
    nxt();
    bus.ex_done = 1'b0;
    bus.instr_valid = 1'b0;
    pin("b2b_add", 1'b1, 21'h00001, 1'b1);
    nxt();

    // JUMP chain 0x040 -> 0x100 -> 0x101
    wr(9'h040, uw(21'h00010, 2'b10, 9'h100));
    wr(9'h100, uw(21'h00020, 2'b10, 9'h101));
    wr(9'h101, uw(21'h00030, 2'b00, 9'h000));
    send(I_ADDI);
    pin("jump0", 1'b1, 21'h00010, 1'b0); nxt();
    pin("jump1", 1'b1, 21'h00020, 1'b0); nxt();
    pin("jump2", 1'b1, 21'h00030, 1'b1); nxt();

    // Same chain with a 2-cycle stall after the first word
    send(I_ADDI);
    pin("sjump0", 1'b1, 21'h00010, 1'b0); nxt();
    bus.stall = 1'b1;
    pin("stall_a", 1'b0, '0, 1'b0); nxt();
    pin("stall_b", 1'b0, '0, 1'b0); nxt();
    bus.stall = 1'b0;
    pin("sjump1", 1'b1, 21'h00020, 1'b0); nxt();
    pin("sjump2", 1'b1, 21'h00030, 1'b1); nxt();

    // COND branch, taken then not taken
    wr(9'h180, uw(21'h00040, 2'b11, 9'h1F0));
    wr(9'h1F0, uw(21'h00050, 2'b00, 9'h000));
    send(I_BEQ);
    bus.cond_in = 1'b1;
    pin("cond_t0", 1'b1, 21'h00040, 1'b0); nxt();
    bus.cond_in = 1'b0;
    pin("cond_t1", 1'b1, 21'h00050, 1'b1); nxt();
    pin("cond_idle", 1'b0, '0, 1'b1); nxt();
    send(I_BEQ);
    pin("cond_n0", 1'b1, 21'h00040, 1'b1); nxt();
    pin("cond_nidle", 1'b0, '0, 1'b1); nxt();

    // Reset in the middle of a STAY sequence
    send(I_STAY);
    pin("pre_rst", 1'b1, 21'h0ABCD, 1'b0);
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    pin("rst_mid", 1'b0, '0, 1'b1); nxt();
    pin("rst_idle", 1'b0, '0, 1'b1); nxt();

`ifdef UCODE_PARITY_EN
    // Corrupted parity aborts the fetch and pulses the error flag
    wr(9'h0C0, uw(21'h00001, 2'b00, 9'h000), 1'b1);
    send(I_ADD);
    pin("perr", 1'b0, '0, 1'b0, 1'b0); nxt();
    pin("perr_flag", 1'b0, '0, 1'b1, 1'b1); nxt();
    pin("perr_clear", 1'b0, '0, 1'b1, 1'b0); nxt();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rstn            = ($urandom_range(0, 199) != 0);
      bus.instr_valid = ($urandom_range(0, 1) == 1);
      bus.instruction = rand_instr();
      bus.ex_done     = ($urandom_range(0, 9) < 3);
      bus.cond_in     = ($urandom_range(0, 1) == 1);
      bus.stall       = ($urandom_range(0, 99) < 15);
      bus.ucode_we    = ($urandom_range(0, 19) == 0);
      bus.ucode_waddr = ADDR_W'($urandom);
      bus.ucode_wdata = rand_word();
      bus.ucode_wpar  = (^bus.ucode_wdata) ^ ($urandom_range(0, 29) == 0);
      nxt();
    end

    rstn = 1'b1;
    bus.instr_valid = 1'b0;
    bus.ucode_we = 1'b0;
    repeat (2) nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
